// File: rtl/cs_seq_if.sv
// Stream and engine-side signal bundle for the CS window sequencer.
// master = sequencer side, slave = sample source / engine / consumer side.
interface cs_seq_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              flush;
  logic [DW-1:0]     eng_x;
  logic              eng_shift;
  logic              eng_clr;
  logic [DW+1:0]     eng_y;
  logic              out_valid;
  logic              out_ready;
  logic [DW+1:0]     out_y;
  logic [CNT_W-1:0]  fill;

  modport master (
    input  in_valid, in_data, flush, eng_y, out_ready,
    output in_ready, eng_x, eng_shift, eng_clr, out_valid, out_y, fill
  );

  modport slave (
    output in_valid, in_data, flush, eng_y, out_ready,
    input  in_ready, eng_x, eng_shift, eng_clr, out_valid, out_y, fill
  );
endinterface

// File: rtl/cs_seq_ctrl.sv
// Sequencer for the 9-tap CS window engine: one shift strobe per accepted sample,
// waits LAT cycles, presents Y. Define CS_WARMUP_OUT_EN to emit results during warm-up too.
module cs_seq_ctrl #(
  parameter int DW    = 8,
  parameter int WIN   = 9,
  parameter int LAT   = 1,
  parameter int CNT_W = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  cs_seq_if.master bus
);

`ifdef CS_WARMUP_OUT_EN
  localparam bit WARM_OUT = 1'b1;
`else
  localparam bit WARM_OUT = 1'b0;
`endif

  localparam int LAT_W = 3;

  typedef enum logic [2:0] {CLEAR, IDLE, SHIFT, WAIT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     x_q, x_d;
  logic [DW+1:0]     y_q, y_d;
  logic              ov_q, ov_d;
  logic              in_ready, eng_shift, eng_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] f);
    return (f >= CNT_W'(WIN)) ? CNT_W'(WIN) : f + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      fill_q  <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
    end
  end

  // CLEAR ignores flush; elsewhere flush pre-empts every other transition.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    ov_d      = ov_q;
    in_ready  = 1'b0;
    eng_shift = 1'b0;
    eng_clr   = 1'b0;
    if (state_q == CLEAR) begin
      eng_clr = 1'b1;
      fill_d  = '0;
      state_d = IDLE;
    end else if (bus.flush) begin
      ov_d    = 1'b0;
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
            x_d     = bus.in_data;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          eng_shift = 1'b1;
          fill_d    = sat_inc(fill_q);
          cnt_d     = LAT_W'(LAT);
          state_d   = WAIT;
        end
        WAIT: begin
          if (cnt_q <= LAT_W'(1)) begin
            y_d = bus.eng_y;
            if (WARM_OUT || fill_q == CNT_W'(WIN)) begin
              ov_d    = 1'b1;
              state_d = HOLD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            ov_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.eng_shift = eng_shift;
  assign bus.eng_clr   = eng_clr;
  assign bus.eng_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_valid = ov_q;
  assign bus.fill      = fill_q;

endmodule
